// File: rtl/rob_commit_retire.sv
// rtl/rob_commit_retire.sv - ROB commit consumer: ARF/cRAT update and free-tag return FIFO
module rob_commit_retire #(
  parameter int PHYS_W     = 7,
  parameter int FREE_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              commit_valid,
  output logic              commit_ready,
  input  logic [31:0]       commit_value,
  input  logic [4:0]        commit_dest,
  input  logic [PHYS_W-1:0] commit_phys_addr,
  input  logic              commit_reg_write,
  input  logic [4:0]        rd_addr1,
  input  logic [4:0]        rd_addr2,
  output logic [31:0]       rd_data1,
  output logic [31:0]       rd_data2,
  output logic              free_valid,
  input  logic              free_ready,
  output logic [PHYS_W-1:0] free_phys,
  output logic [3:0]        free_level,
  output logic [31:0]       retire_count
);

  localparam int AW = $clog2(FREE_DEPTH);

  logic [31:0]       r_arf  [32];
  logic [PHYS_W-1:0] r_crat [32];
  logic [PHYS_W-1:0] r_fifo [FREE_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [3:0]        r_level;
  logic [31:0]       r_retire_count;

  logic              w_accept;
  logic              w_write;
  logic              w_push;
  logic              w_pop;
  logic [PHYS_W-1:0] w_old_phys;

  assign commit_ready = (r_level != 4'(FREE_DEPTH));
  assign w_accept     = commit_valid & commit_ready;
  assign w_write      = w_accept & commit_reg_write & (commit_dest != 5'd0);
  assign w_old_phys   = r_crat[commit_dest];
  // Re-committing the tag already mapped must not release it to the free list.
  assign w_push       = w_write & (w_old_phys != commit_phys_addr);
  assign w_pop        = free_valid & free_ready;

  assign free_valid   = (r_level != 4'd0);
  assign free_phys    = r_fifo[r_rd_ptr];
  assign free_level   = r_level;
  assign retire_count = r_retire_count;

  assign rd_data1 = (rd_addr1 == 5'd0) ? 32'd0 : r_arf[rd_addr1];
  assign rd_data2 = (rd_addr2 == 5'd0) ? 32'd0 : r_arf[rd_addr2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        r_arf[i]  <= 32'd0;
        r_crat[i] <= PHYS_W'(i);
      end
      for (int j = 0; j < FREE_DEPTH; j++) begin
        r_fifo[j] <= '0;
      end
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_level        <= 4'd0;
      r_retire_count <= 32'd0;
    end else begin
      if (w_accept) begin
        r_retire_count <= r_retire_count + 32'd1;
      end
      if (w_write) begin
        r_arf[commit_dest]  <= commit_value;
        r_crat[commit_dest] <= commit_phys_addr;
      end
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_old_phys;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 4'd1;
        2'b01:   r_level <= r_level - 4'd1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule
